tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
// - CP0-side initiator for TLB maintenance; it drives the MMU's tlb_config / tlbwi / tlbp inputs and consumes tlbp_result.
// - Accepts TLBWI/TLBWR/TLBP ops from the pipeline and packs EntryHi/EntryLo0/EntryLo1 into the 84-bit config.
// - Sequences the write/probe strobes, writes probe results back to Index, and owns the Random register.
// PARAMETERS
// - TLB_ENTRIES  16  entry count; power of 2, at most 16 (index field is 4 bits)
// PORTS
// - clk          in   1   single clock; all state on rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - op_valid     in   1   TLB op request from the MEM stage
// - op_code      in   2   00 TLBWI, 01 TLBWR, 10 TLBP, 11 reserved (accepted, no effect)
// - op_ready     out  1   high when the block can accept an op (state IDLE)
// - busy         out  1   pipeline stall request; equals ~op_ready
// - entry_hi     in   32  CP0 EntryHi: VPN2=[31:13], ASID=[7:0]
// - entry_lo0    in   32  CP0 EntryLo0: PFN=[29:6], D=[2], V=[1], G=[0]
// - entry_lo1    in   32  CP0 EntryLo1, same layout as EntryLo0
// - index_i      in   32  CP0 Index; [3:0] is used
// - wired_i      in   4   CP0 Wired value
// - wired_we     in   1   Wired is written this cycle
// - tlb_config   out  84  {idx[3:0], vpn2[18:0], asid[7:0], g, pfn1[23:0], d1, v1, pfn0[23:0], d0, v0}
// - tlbwi        out  1   one-cycle TLB write strobe
// - tlbp         out  1   one-cycle TLB probe strobe
// - tlbp_result  in   32  probe result from the MMU: [31]=miss (P), [3:0]=hit index
// - index_we     out  1   write strobe for CP0 Index
// - index_wdata  out  32  {P, 27'b0, idx[3:0]}
// - random_o     out  32  CP0 Random value for MFC0, zero-extended
// BEHAVIOUR
// - Reset values: state=IDLE, tlb_config=0, tlbwi=0, tlbp=0, index_we=0, index_wdata=0, random=TLB_ENTRIES-1, op_ready=1, busy=0.
// - Accept: op_valid & op_ready. At accept, register tlb_config.
//   - g = lo0.G & lo1.G.
//   - idx = index_i[3:0] for TLBWI; idx = current random for TLBWR.
// - FSM states: IDLE, WRITE, PROBE, PROBE_WAIT.
// - TLBWI/TLBWR: IDLE -> WRITE -> IDLE.
//   - tlbwi=1 only during WRITE, with tlb_config already stable.
//   - Latency: 1 busy cycle.
// - TLBP: IDLE -> PROBE -> PROBE_WAIT -> IDLE.
//   - tlbp=1 during PROBE.
//   - In PROBE_WAIT, tlbp_result is sampled: index_we=1 for exactly that cycle, index_wdata={tlbp_result[31], 27'b0, tlbp_result[3:0]}.
//   - Latency: 2 busy cycles.
// - Op 11: accepted in IDLE, stays IDLE, no strobes.
// - op_valid while busy is ignored. The pipeline holds the request until op_ready.
// - tlb_config holds its last value between ops. It changes only at accept.
// - Random (4-bit counter) is updated every cycle:
//   - Default: decrement.
//   - If random==wired_i, or random==0: reload TLB_ENTRIES-1.
//   - If wired_i >= TLB_ENTRIES-1: random stays TLB_ENTRIES-1.
//   - wired_we has priority: random <= TLB_ENTRIES-1.
// - Simultaneous TLBWR accept and random update/wired_we: TLBWR uses the pre-update random value.
// - Reset mid-op (any state): strobes drop asynchronously, state returns to IDLE, no partial Index write.
// CONFIGURATION
// - TLBWR_EN defined: TLBWR is supported as described; Random counts as specified.
// - TLBWR_EN undefined:
//   - op_code 01 is treated as reserved (accepted, no tlbwi).
//   - random_o is constant TLB_ENTRIES-1.
//   - The counter logic is not built.
// TESTING
// - T1 TLBWI: index=5, entry_hi=0x00402005, lo0=0x00000047, lo1=0x00000087 -> one cycle later tlbwi=1 for 1 cycle, tlb_config idx=5, vpn2=0x00201, asid=0x05, g=1, pfn0=1, pfn1=2, d/v=1/1.
// - T2 TLBP hit: tlbp_result=0x00000009 -> tlbp pulse, then index_we=1 with index_wdata=0x00000009. busy is high for exactly 2 cycles.
// - T3 TLBP miss: tlbp_result=0x80000000 -> index_wdata=0x80000000. No tlbwi at any point.
// - T4 Random: wired_i=3 after reset -> random_o sequence 15,14,...,3,15. wired_we pulse mid-count -> next value 15.
// - T5 TLBWR (TLBWR_EN): issue when random_o=7 -> tlb_config idx=7. Without the macro -> no tlbwi, random_o stays 15.
// - T6 Back-to-back: TLBP held valid during WRITE is accepted only when op_ready returns. Assert rst_n low during PROBE_WAIT -> no index_we, state IDLE.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: pipeline/MMU-facing signals of the CP0 TLB maintenance sequencer.
interface tlb_op_ctrl_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic        busy;
  logic [31:0] entry_hi;
  logic [31:0] entry_lo0;
  logic [31:0] entry_lo1;
  logic [31:0] index_i;
  logic [3:0]  wired_i;
  logic        wired_we;
  logic [83:0] tlb_config;
  logic        tlbwi;
  logic        tlbp;
  logic [31:0] tlbp_result;
  logic        index_we;
  logic [31:0] index_wdata;
  logic [31:0] random_o;
  modport slave (
    input  op_valid, op_code, entry_hi, entry_lo0, entry_lo1, index_i,
           wired_i, wired_we, tlbp_result,
    output op_ready, busy, tlb_config, tlbwi, tlbp, index_we, index_wdata, random_o
  );
  modport master (
    output op_valid, op_code, entry_hi, entry_lo0, entry_lo1, index_i,
           wired_i, wired_we, tlbp_result,
    input  op_ready, busy, tlb_config, tlbwi, tlbp, index_we, index_wdata, random_o
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: CP0-side TLB maintenance sequencer (TLBWI/TLBWR/TLBP, Index write-back, Random).
// TLBWR and the Random counter are built only when TLBWR_EN is defined.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16
) (
  input logic          clk,
  input logic          rst_n,
  tlb_op_ctrl_if.slave bus
);
  localparam logic [3:0] RND_MAX = 4'(TLB_ENTRIES - 1);
  typedef enum logic [1:0] {IDLE, WRITE, PROBE, PROBE_WAIT} state_t;
  state_t      state_q, state_d;
  logic [83:0] cfg_q, cfg_d;
  logic [3:0]  rnd_q;
  logic [3:0]  idx;
  logic        accept, is_wr, is_wi, is_p;
  logic        unused;
  assign accept = bus.op_valid & bus.op_ready;
  assign is_wi  = bus.op_code == 2'b00;
  assign is_p   = bus.op_code == 2'b10;
`ifdef TLBWR_EN
  logic [3:0] rnd_d;
  assign is_wr = bus.op_code == 2'b01;
  // Wired write wins; a Wired at/above the top pins Random at the top entry.
  assign rnd_d = (bus.wired_we || bus.wired_i >= RND_MAX || rnd_q == bus.wired_i || rnd_q == 4'd0)
                 ? RND_MAX : rnd_q - 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rnd_q <= RND_MAX;
    else        rnd_q <= rnd_d;
  assign unused = ^{bus.entry_hi[12:8], bus.entry_lo0[31:30], bus.entry_lo0[5:3],
                    bus.entry_lo1[31:30], bus.entry_lo1[5:3], bus.index_i[31:4],
                    bus.tlbp_result[30:4]};
`else
  assign is_wr  = 1'b0;
  assign rnd_q  = RND_MAX;
  assign unused = ^{bus.entry_hi[12:8], bus.entry_lo0[31:30], bus.entry_lo0[5:3],
                    bus.entry_lo1[31:30], bus.entry_lo1[5:3], bus.index_i[31:4],
                    bus.tlbp_result[30:4], bus.wired_i, bus.wired_we};
`endif
  // TLBWR captures Random as it was before this cycle's update.
  assign idx   = is_wr ? rnd_q : bus.index_i[3:0];
  assign cfg_d = {idx, bus.entry_hi[31:13], bus.entry_hi[7:0],
                  bus.entry_lo0[0] & bus.entry_lo1[0],
                  bus.entry_lo1[29:6], bus.entry_lo1[2], bus.entry_lo1[1],
                  bus.entry_lo0[29:6], bus.entry_lo0[2], bus.entry_lo0[1]};
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : (is_wi || is_wr) ? WRITE : is_p ? PROBE : IDLE;
      PROBE:   state_d = PROBE_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cfg_q <= cfg_d;
    end
  assign bus.op_ready    = state_q == IDLE;
  assign bus.busy        = state_q != IDLE;
  assign bus.tlbwi       = state_q == WRITE;
  assign bus.tlbp        = state_q == PROBE;
  assign bus.index_we    = state_q == PROBE_WAIT;
  assign bus.index_wdata = bus.index_we ? {bus.tlbp_result[31], 27'b0, bus.tlbp_result[3:0]} : 32'b0;
  assign bus.tlb_config  = cfg_q;
  assign bus.random_o    = {28'b0, rnd_q};
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed and randomized bench for tlb_op_ctrl against a strobe-schedule reference model.
module tb_tlb_op_ctrl;
  localparam logic [3:0] MAX = 4'd15;
`ifdef TLBWR_EN
  localparam bit WREN = 1'b1;
`else
  localparam bit WREN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tlb_op_ctrl_if bus();
  tlb_op_ctrl #(.TLB_ENTRIES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [83:0] mk_cfg(input logic [3:0] idx, input logic [31:0] hi,
                                         input logic [31:0] lo0, input logic [31:0] lo1);
    return {idx, hi[31:13], hi[7:0], lo0[0] & lo1[0], lo1[29:6], lo1[2], lo1[1],
            lo0[29:6], lo0[2], lo0[1]};
  endfunction
  // Model: each accepted op schedules the strobe expected on each following cycle.
  typedef enum int {E_WI, E_P, E_WE} ev_t;
  ev_t         sched[$];
  logic [83:0] m_cfg = '0;
  logic [3:0]  m_rnd = MAX;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sched.delete();
      m_cfg <= '0;
      m_rnd <= MAX;
    end else begin
      m_rnd <= (bus.wired_we || bus.wired_i >= MAX || m_rnd == bus.wired_i || m_rnd == 4'd0)
               ? MAX : m_rnd - 4'd1;
      if (sched.size() != 0) void'(sched.pop_front());
      else if (bus.op_valid) begin
        m_cfg <= mk_cfg((bus.op_code == 2'b01 && WREN) ? m_rnd : bus.index_i[3:0],
                        bus.entry_hi, bus.entry_lo0, bus.entry_lo1);
        if (bus.op_code == 2'b00 || (bus.op_code == 2'b01 && WREN)) sched.push_back(E_WI);
        else if (bus.op_code == 2'b10) begin
          sched.push_back(E_P);
          sched.push_back(E_WE);
        end
      end
    end
  always @(negedge clk) begin
    logic e_wi, e_p, e_we, idle;
    idle = sched.size() == 0;
    e_wi = !idle && sched[0] == E_WI;
    e_p  = !idle && sched[0] == E_P;
    e_we = !idle && sched[0] == E_WE;
    chk("m_op_ready", 84'(bus.op_ready), 84'(idle));
    chk("m_busy", 84'(bus.busy), 84'(!idle));
    chk("m_tlbwi", 84'(bus.tlbwi), 84'(e_wi));
    chk("m_tlbp", 84'(bus.tlbp), 84'(e_p));
    chk("m_index_we", 84'(bus.index_we), 84'(e_we));
    chk("m_index_wdata", 84'(bus.index_wdata),
        e_we ? 84'({bus.tlbp_result[31], 27'b0, bus.tlbp_result[3:0]}) : 84'(0));
    chk("m_tlb_config", bus.tlb_config, m_cfg);
    chk("m_random", 84'(bus.random_o), WREN ? 84'(m_rnd) : 84'(MAX));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] code);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    tick();
    bus.op_valid = 1'b0;
  endtask
  initial begin
    bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.entry_hi = '0; bus.entry_lo0 = '0;
    bus.entry_lo1 = '0; bus.index_i = '0; bus.wired_i = 4'd3; bus.wired_we = 1'b0;
    bus.tlbp_result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_op_ready", 84'(bus.op_ready), 84'(1));
    chk("rst_busy", 84'(bus.busy), 84'(0));
    chk("rst_strobes", 84'({bus.tlbwi, bus.tlbp, bus.index_we}), 84'(0));
    chk("rst_index_wdata", 84'(bus.index_wdata), 84'(0));
    chk("rst_tlb_config", bus.tlb_config, 84'(0));
    chk("rst_random", 84'(bus.random_o), 84'(15));
    // Random walk 15..3 then reload with Wired=3
    for (int k = 0; k < 14; k++) begin
      chk("rnd_seq", 84'(bus.random_o), WREN ? 84'((k <= 12) ? 15 - k : 15) : 84'(15));
      tick();
    end
    repeat (4) tick();
    chk("rnd_pre_we", 84'(bus.random_o), WREN ? 84'(10) : 84'(15));
    bus.wired_we = 1'b1;
    tick();
    bus.wired_we = 1'b0;
    chk("rnd_wired_we", 84'(bus.random_o), 84'(15));
    tick();
    chk("rnd_after_we", 84'(bus.random_o), WREN ? 84'(14) : 84'(15));
    // T1 TLBWI
    bus.index_i = 32'd5; bus.entry_hi = 32'h00402005;
    bus.entry_lo0 = 32'h00000047; bus.entry_lo1 = 32'h00000087;
    issue(2'b00);
    chk("t1_tlbwi", 84'(bus.tlbwi), 84'(1));
    chk("t1_busy", 84'(bus.busy), 84'(1));
    chk("t1_config", bus.tlb_config,
        {4'd5, 19'h00201, 8'h05, 1'b1, 24'd2, 1'b1, 1'b1, 24'd1, 1'b1, 1'b1});
    tick();
    chk("t1_tlbwi_off", 84'(bus.tlbwi), 84'(0));
    chk("t1_ready", 84'(bus.op_ready), 84'(1));
    chk("t1_config_hold", bus.tlb_config,
        {4'd5, 19'h00201, 8'h05, 1'b1, 24'd2, 1'b1, 1'b1, 24'd1, 1'b1, 1'b1});
    // T2 TLBP hit, T3 TLBP miss
    for (int t = 0; t < 2; t++) begin
      bus.tlbp_result = (t == 0) ? 32'h00000009 : 32'h80000000;
      issue(2'b10);
      chk("tp_tlbp", 84'({bus.tlbp, bus.busy, bus.index_we, bus.tlbwi}), 84'(4'b1100));
      tick();
      chk("tp_index_we", 84'({bus.tlbp, bus.busy, bus.index_we, bus.tlbwi}), 84'(4'b0110));
      chk("tp_index_wdata", 84'(bus.index_wdata), (t == 0) ? 84'(32'h00000009) : 84'(32'h80000000));
      tick();
      chk("tp_done", 84'({bus.tlbp, bus.busy, bus.index_we, bus.tlbwi}), 84'(4'b0000));
    end
    // T5 TLBWR
    bus.index_i = 32'd2;
`ifdef TLBWR_EN
    for (int k = 0; k < 40 && bus.random_o != 32'd7; k++) tick();
    chk("t5_wait_rnd7", 84'(bus.random_o), 84'(7));
    issue(2'b01);
    chk("t5_tlbwi", 84'(bus.tlbwi), 84'(1));
    chk("t5_idx", 84'(bus.tlb_config[83:80]), 84'(7));
`else
    issue(2'b01);
    chk("t5_no_tlbwi", 84'(bus.tlbwi), 84'(0));
    chk("t5_no_busy", 84'(bus.busy), 84'(0));
    chk("t5_random", 84'(bus.random_o), 84'(15));
`endif
    tick();
    // T6 back-to-back hold, then reset during PROBE_WAIT
    bus.op_valid = 1'b1; bus.op_code = 2'b00;
    tick();
    bus.op_code = 2'b10;
    chk("t6_write", 84'(bus.tlbwi), 84'(1));
    tick();
    chk("t6_not_taken", 84'({bus.op_ready, bus.tlbp}), 84'(2'b10));
    tick();
    bus.op_valid = 1'b0;
    chk("t6_probe", 84'(bus.tlbp), 84'(1));
    tick();
    chk("t6_probe_wait", 84'(bus.index_we), 84'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_index_we", 84'(bus.index_we), 84'(0));
    chk("t6_rst_idle", 84'({bus.op_ready, bus.busy, bus.tlbwi, bus.tlbp}), 84'(4'b1000));
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst", 84'({bus.op_ready, bus.index_we}), 84'(2'b10));
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.op_valid    = $urandom_range(0, 2) != 0;
      bus.op_code     = 2'($urandom);
      bus.entry_hi    = $urandom;
      bus.entry_lo0   = $urandom;
      bus.entry_lo1   = $urandom;
      bus.index_i     = $urandom;
      bus.tlbp_result = $urandom;
      bus.wired_we    = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 49) == 0) bus.wired_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    bus.op_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
